// File: rtl/calc_pkg.sv
// Shared constants for the board calculator.
//  - BTN_*: index of each push-button inside btn_level / btn_pulse.
//  - NUM_BTN, SW_WIDTH: board I/O widths.
//  - DEBOUNCE_CYCLES: default debounce window (10 ms at 100 MHz).
package calc_pkg;

  localparam int BTN_C           = 0;
  localparam int BTN_L           = 1;
  localparam int BTN_U           = 2;
  localparam int BTN_R           = 3;
  localparam int BTN_D           = 4;
  localparam int NUM_BTN         = 5;
  localparam int SW_WIDTH        = 16;
  localparam int DEBOUNCE_CYCLES = 1_000_000;

endpackage

// File: rtl/debounce_cell.sv
// Single push-button conditioner: 2-FF synchroniser, debounce counter and a
// one-cycle pulse on each accepted press.
// Ports:
//  clk    in  system clock
//  rst    in  asynchronous active-high reset
//  raw    in  raw (asynchronous, bouncy) button input
//  level  out debounced level
//  pulse  out one-cycle high on each accepted 0->1 transition
module debounce_cell #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          stable;
  logic [CW-1:0] cnt;
  logic          done;

  // The synced input has disagreed with the stable state for the whole window.
  assign done = (s2 != stable) && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      pulse  <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      // Only rising acceptance fires; it coincides with level going high.
      pulse <= done && s2;
      if (s2 == stable) begin
        // Any return to the stable value throws away partial progress.
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign level = stable;

endmodule

// File: rtl/btn_conditioner.sv
// Front end for the board calculator: conditions the five raw push-buttons
// (one debounce_cell each) and synchronises the switch bank.
// Ports:
//  clk        in  system clock
//  rst        in  asynchronous active-high reset
//  btnc..btnd in  raw buttons (async, bouncy)
//  sw         in  raw switches (async)
//  btn_level  out debounced button levels, indexed by calc_pkg::BTN_*
//  btn_pulse  out one-cycle press strobes, same indexing
//  sw_sync    out switches after a 2-FF synchroniser (no debounce)
module btn_conditioner
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = calc_pkg::DEBOUNCE_CYCLES,
  parameter int NUM_BTN         = calc_pkg::NUM_BTN,
  parameter int SW_WIDTH        = calc_pkg::SW_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btnc,
  input  logic                btnl,
  input  logic                btnu,
  input  logic                btnr,
  input  logic                btnd,
  input  logic [SW_WIDTH-1:0] sw,
  output logic [NUM_BTN-1:0]  btn_level,
  output logic [NUM_BTN-1:0]  btn_pulse,
  output logic [SW_WIDTH-1:0] sw_sync
);

  logic [NUM_BTN-1:0]  raw_btn;
  logic [SW_WIDTH-1:0] sw_s1;

  // Pack the named buttons into a vector so calc can index by BTN_*.
  assign raw_btn[BTN_C] = btnc;
  assign raw_btn[BTN_L] = btnl;
  assign raw_btn[BTN_U] = btnu;
  assign raw_btn[BTN_R] = btnr;
  assign raw_btn[BTN_D] = btnd;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clk  (clk),
      .rst  (rst),
      .raw  (raw_btn[i]),
      .level(btn_level[i]),
      .pulse(btn_pulse[i])
    );
  end

  // Switches are static settings; metastability protection is all they need.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_s1   <= '0;
      sw_sync <= '0;
    end else begin
      sw_s1   <= sw;
      sw_sync <= sw_s1;
    end
  end

endmodule
